apb4_cmd_master: RTL
====================

// Module: apb4_cmd_master
// PURPOSE
// - Synthesisable APB4 master transactor driven by a valid/ready command stream instead of blocking tasks.
// - Buffers up to CMD_DEPTH commands and runs them in order as APB SETUP/ACCESS transfers.
// - Returns one response per command: read data, slave error, timeout.
// - Sits between the testbench command channel (DPI/SFIFO side) and the DUT APB slave port.
// PARAMETERS
// ADDR_WIDTH   32   paddr / cmd_addr width
// DATA_WIDTH   32   pwdata/prdata width; multiple of 8
// CMD_DEPTH    4    command FIFO entries (>=2)
// TIMEOUT      100  ACCESS cycles without pready before abort; 0 = no timeout
// TIMER_WIDTH  8    timer width; must hold TIMEOUT
// PORTS
// clk          in   1             clock, all logic on rising edge
// reset_n      in   1             synchronous reset, active-low
// cmd_valid    in   1             command present
// cmd_ready    out  1             command FIFO not full
// cmd_write    in   1             1=write, 0=read
// cmd_addr     in   ADDR_WIDTH    transfer address
// cmd_wdata    in   DATA_WIDTH    write data
// cmd_strb     in   DATA_WIDTH/8  write byte strobes
// cmd_prot     in   3             pprot value
// rsp_valid    out  1             response held
// rsp_ready    in   1             response consumed
// rsp_rdata    out  DATA_WIDTH    read data (0 for writes/timeouts)
// rsp_err      out  1             pslverr or timeout
// rsp_timeout  out  1             transfer aborted by timer
// psel/penable/pwrite out 1       APB controls
// paddr        out  ADDR_WIDTH    APB address
// pwdata       out  DATA_WIDTH    APB write data
// pstrb        out  DATA_WIDTH/8  APB strobes
// pprot        out  3             APB protection
// prdata       in   DATA_WIDTH    APB read data
// pready       in   1             APB ready
// pslverr      in   1             APB error, valid only with pready
// busy         out  1             state!=IDLE | FIFO non-empty | rsp_valid
// BEHAVIOUR
// - Reset (reset_n=0 at edge): all outputs 0 (cmd_ready=0 while in reset), FIFO emptied, timer=0, state IDLE.
//   Reset mid-transfer abandons the transfer; no response produced.
// - cmd_ready = !full (registered count, width clog2(CMD_DEPTH+1)).
//   Push on cmd_valid&cmd_ready. No push when full, even on a same-cycle pop. No FIFO bypass.
// - FSM IDLE->SETUP->ACCESS->IDLE; all APB outputs registered.
//   IDLE: if FIFO non-empty and (!rsp_valid | rsp_ready): pop, load paddr/pwrite/pprot, psel=1, penable=0.
//     pwdata=cmd_wdata and pstrb=cmd_strb for writes; pwdata=0 and pstrb=0 for reads. Go SETUP.
//   SETUP: penable=1, timer=0, go ACCESS.
//   ACCESS, pready=1: complete; psel/penable/pwrite/paddr/pwdata/pstrb/pprot <=0; rsp_valid<=1;
//     rsp_rdata<=read?prdata:0; rsp_err<=pslverr; rsp_timeout<=0; go IDLE.
//   ACCESS, pready=0: timer++. If TIMEOUT!=0 and this is the TIMEOUT-th wait cycle, abort like completion
//     with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
// - APB inputs stable across ACCESS wait states; pslverr ignored when pready=0.
// - Latency, zero-wait slave: push at E0, psel high after E1, penable after E2, rsp_valid after E3.
//   psel is low >=1 cycle between transfers.
// - rsp_* held stable until rsp_valid&rsp_ready; rsp_valid cleared next edge unless a new completion occurs.
// - Commands execute and respond strictly in push order.
// TESTING
// - Write 0x100/0xDEADBEEF/strb 0xF, zero-wait -> APB phases at E1/E2, rsp_valid after E3, err=0, rdata=0.
// - Read 0x200, 3 wait states, prdata=0x12345678 -> penable high 4 cycles, pstrb=0, rsp_rdata=0x12345678.
// - pready stuck 0, TIMEOUT=100 -> abort after 100 ACCESS cycles, rsp_err=1, rsp_timeout=1, rdata=0.
// - CMD_DEPTH=4, rsp_ready=0, offer 6 cmds -> 5 accepted, cmd_ready=0; rsp_ready=1 -> remaining 4 in order.
// - Read with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0; next queued command still runs.
// - reset_n=0 mid-ACCESS -> all APB outputs 0 next edge, no rsp_valid, FIFO empty, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb4_cmd_master_if.sv
// rtl/apb4_cmd_master_if.sv - command, response and APB signal bundle for apb4_cmd_master
interface apb4_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;
    logic [2:0]            cmd_prot;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    // master: the transactor; slave: the command source plus the APB slave it drives
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_cmd_master.sv
// rtl/apb4_cmd_master.sv - APB4 master driven by a buffered valid/ready command stream
module apb4_cmd_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT     = 100,
    parameter int TIMER_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    apb4_cmd_master_if.master bus,
    output logic              busy
);
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int ENTRY_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH + 3;
    localparam int PTR_WIDTH   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_WIDTH   = $clog2(CMD_DEPTH + 1);

    localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(CMD_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]   FULL_CNT   = CNT_WIDTH'(CMD_DEPTH);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state, state_next;

    logic [ENTRY_WIDTH-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]   count;
    logic                   live;
    logic                   push, pop, complete, abort;
    logic [TIMER_WIDTH-1:0] timer;

    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [STRB_WIDTH-1:0] head_strb;
    logic [2:0]            head_prot;

    assign {head_write, head_addr, head_wdata, head_strb, head_prot} = fifo_mem[rd_ptr];

    // live keeps cmd_ready low for the whole reset period, not just after it
    assign bus.cmd_ready = live && (count != FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign busy          = (state != IDLE) || (count != '0) || bus.rsp_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb, bus.cmd_prot};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new transfer starts only when its response will have a free slot to land in
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && (!bus.rsp_valid || bus.rsp_ready)) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if ((TIMEOUT != 0) && (timer == TIMER_LAST)) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.pwrite      <= 1'b0;
            bus.paddr       <= '0;
            bus.pwdata      <= '0;
            bus.pstrb       <= '0;
            bus.pprot       <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            timer           <= '0;
        end else begin
            if (pop) begin
                bus.psel    <= 1'b1;
                bus.penable <= 1'b0;
                bus.pwrite  <= head_write;
                bus.paddr   <= head_addr;
                bus.pprot   <= head_prot;
                bus.pwdata  <= head_write ? head_wdata : '0;
                bus.pstrb   <= head_write ? head_strb : '0;
            end
            if (state == SETUP) begin
                bus.penable <= 1'b1;
                timer       <= '0;
            end
            if ((state == ACCESS) && !bus.pready) begin
                timer <= timer + 1'b1;
            end
            if (complete || abort) begin
                bus.psel        <= 1'b0;
                bus.penable     <= 1'b0;
                bus.pwrite      <= 1'b0;
                bus.paddr       <= '0;
                bus.pwdata      <= '0;
                bus.pstrb       <= '0;
                bus.pprot       <= '0;
                bus.rsp_valid   <= 1'b1;
                bus.rsp_rdata   <= (complete && !bus.pwrite) ? bus.prdata : '0;
                bus.rsp_err     <= abort ? 1'b1 : bus.pslverr;
                bus.rsp_timeout <= abort;
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule
